i2c_byte_tx: RTL

Byte-level I2C write engine for the master. It generates SCL and the START/STOP conditions, serialises one byte MSB-first, and samples the slave ACK. It does not drive SDA directly. It drives the three inputs of the downstream 2:1 SDA mux: sda_shift to i0, sda_ctrl to i1, and sda_sel to sel. The mux output goes to the open-drain pad logic, where 1 means released.

---
 rtl/i2c_byte_tx_pkg.sv | 60 ++++++
 rtl/i2c_byte_tx_if.sv | 28 ++
 rtl/i2c_quarter_tick.sv | 32 +++
 rtl/i2c_byte_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/i2c_byte_tx_pkg.sv
// Shared types and defaults for the I2C byte write engine.
`timescale 1ns/1ps
package i2c_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ACK,
    STOP,
    HOLD
  } state_t;

  typedef logic [1:0] phase_t;

  // Levels presented to SCL and to the three inputs of the downstream SDA mux.
  typedef struct packed {
    logic scl;
    logic ctrl;
    logic sel;
    logic shift;
  } bus_drv_t;

  // Bus levels for a given state and quarter phase; msb is the bit being sent.
  function automatic bus_drv_t bus_drive(state_t st, phase_t ph, logic msb);
    bus_drv_t d;
    d.scl   = 1'b1;
    d.ctrl  = 1'b1;
    d.sel   = 1'b1;
    d.shift = 1'b1;
    case (st)
      START: begin
        d.scl  = ~ph[1];
        d.ctrl = (ph == 2'd0);
      end
      DATA: begin
        d.sel   = 1'b0;
        d.scl   = ph[1];
        d.shift = msb;
      end
      ACK: begin
        d.sel = 1'b0;
        d.scl = ph[1];
      end
      STOP: begin
        d.scl  = ph[1];
        d.ctrl = (ph == 2'd3);
      end
      HOLD: begin
        d.scl  = 1'b0;
        d.ctrl = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_byte_tx_if.sv
// Request/status and bus-level signals of the I2C byte write engine.
`timescale 1ns/1ps
interface i2c_byte_tx_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       stop_after;
  logic       stop_req;
  logic       sda_in;
  logic       scl_out;
  logic       sda_shift;
  logic       sda_ctrl;
  logic       sda_sel;
  logic       busy;
  logic       done;
  logic       ack_err;

  // Controller side: issues requests, supplies the pad level.
  modport master (
    output start, tx_byte, stop_after, stop_req, sda_in,
    input  scl_out, sda_shift, sda_ctrl, sda_sel, busy, done, ack_err
  );

  // Engine side.
  modport slave (
    input  start, tx_byte, stop_after, stop_req, sda_in,
    output scl_out, sda_shift, sda_ctrl, sda_sel, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period tick generator; counter idles at zero while run is low.
`timescale 1ns/1ps
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned     CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count of each quarter; wrap or clear otherwise.
  always_comb begin
    tick  = run && (cnt_q == CNT_MAX);
    cnt_d = '0;
    if (run && !tick) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_byte_tx.sv
// I2C master byte write engine: START/STOP generation, MSB-first shift, ACK sample.
`timescale 1ns/1ps
module i2c_byte_tx
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  i2c_byte_tx_if.slave bus
);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       stop_after_q, stop_after_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       scl_q, ctrl_q, sel_q, shift_q;
  bus_drv_t   drv;
  logic       run;
  logic       tick;

  assign run = (state_q != IDLE) && (state_q != HOLD);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // Next-state logic; bus levels are derived from the next state so every
  // output is a register and changes exactly at the quarter boundary.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    stop_after_d = stop_after_q;
    ack_err_d    = ack_err_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d      = bus.tx_byte;
          stop_after_d = bus.stop_after;
          ack_err_d    = 1'b0;
          phase_d      = '0;
          state_d      = START;
        end
      end
      START: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d  = DATA;
            bitcnt_d = 3'd7;
          end
        end
      end
      DATA: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            if (bitcnt_q == 3'd0) state_d = ACK;
            else                  bitcnt_d = bitcnt_q - 3'd1;
          end
        end
      end
      ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) ack_err_d = bus.sda_in;
          if (phase_q == 2'd3) begin
            if (stop_after_q) begin
              state_d = STOP;
            end else begin
              state_d = HOLD;
              done_d  = 1'b1;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.start) begin
          shreg_d      = bus.tx_byte;
          stop_after_d = bus.stop_after;
          ack_err_d    = 1'b0;
          bitcnt_d     = 3'd7;
          phase_d      = '0;
          state_d      = DATA;
        end else if (bus.stop_req) begin
          phase_d = '0;
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
    drv    = bus_drive(state_d, phase_d, shreg_d[7]);
    busy_d = (state_d != IDLE) && (state_d != HOLD);
  end

  // FSM, datapath and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      stop_after_q <= 1'b0;
      ack_err_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      scl_q        <= 1'b1;
      ctrl_q       <= 1'b1;
      sel_q        <= 1'b1;
      shift_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      stop_after_q <= stop_after_d;
      ack_err_q    <= ack_err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      scl_q        <= drv.scl;
      ctrl_q       <= drv.ctrl;
      sel_q        <= drv.sel;
      shift_q      <= drv.shift;
    end
  end

  assign bus.scl_out   = scl_q;
  assign bus.sda_ctrl  = ctrl_q;
  assign bus.sda_sel   = sel_q;
  assign bus.sda_shift = shift_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;

endmodule
